regfile_mp: RTL and testbench

Parametrised multi-port integer register file for the dual-issue pipeline. It provides NUM_RD combinational read ports and NUM_WR write ports, with same-cycle write-to-read bypass and x0 hardwired to zero. A per-register busy scoreboard is set at issue and cleared at writeback, so decode can detect RAW hazards without a separate hazard table. Writes and scoreboard updates freeze while the pipeline is stalled.

---
 rtl/regfile_pkg.sv | 37 +++
 rtl/regfile_mp_if.sv | 33 +++
 rtl/regfile_bypass_mux.sv | 34 +++
 rtl/regfile_mp.sv | 83 ++++++++
 tb/tb_regfile_mp.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared constants, types and the write-port match helper for the multi-port register file.
package regfile_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int NUM_REGS_DEF = 32;
    localparam int AW_DEF       = $clog2(NUM_REGS_DEF);

    // Match vectors are padded to these maxima so one function serves every parameterisation.
    localparam int MAX_WR       = 8;
    localparam int MAX_AW       = 8;
    localparam int MAX_WR_IDX_W = $clog2(MAX_WR);

    typedef logic [AW_DEF-1:0] reg_addr_t;

    typedef struct packed {
        logic                    hit;
        logic [MAX_WR_IDX_W-1:0] idx;
    } wr_match_t;

    // Later ports overwrite earlier hits, so the youngest matching writer wins.
    function automatic wr_match_t wr_match(
        input logic [MAX_WR-1:0]             en,
        input logic [MAX_WR-1:0][MAX_AW-1:0] addr,
        input logic [MAX_AW-1:0]             target
    );
        wr_match_t m;
        m = '0;
        for (int k = 0; k < MAX_WR; k++) begin
            if (en[k] && (target != '0) && (addr[k] == target)) begin
                m.hit = 1'b1;
                m.idx = MAX_WR_IDX_W'(k);
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Read, write and issue signals between the pipeline and the register file.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2
);
    localparam int AW = $clog2(NUM_REGS);

    logic                           stall;
    logic                           rd_en;
    logic [NUM_RD-1:0][AW-1:0]      rd_addr;
    logic [NUM_RD-1:0][DATA_W-1:0]  rd_data;
    logic [NUM_RD-1:0]              rd_busy;
    logic [NUM_WR-1:0]              wr_en;
    logic [NUM_WR-1:0][AW-1:0]      wr_addr;
    logic [NUM_WR-1:0][DATA_W-1:0]  wr_data;
    logic                           iss_en;
    logic [AW-1:0]                  iss_addr;

    modport master (
        output stall, rd_en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data, rd_busy
    );

    modport slave (
        input  stall, rd_en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data, rd_busy
    );

endinterface

// File: rtl/regfile_bypass_mux.sv
// One read port: picks bypassed write data over array contents and reports the busy flag.
module regfile_bypass_mux
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int AW     = AW_DEF
) (
    input  logic                             rst,
    input  logic                             gate,
    input  logic [AW-1:0]                    rd_addr,
    input  logic [MAX_WR-1:0]                wr_en,
    input  logic [MAX_WR-1:0][MAX_AW-1:0]    wr_addr,
    input  logic [MAX_WR-1:0][DATA_W-1:0]    wr_data,
    input  logic [DATA_W-1:0]                arr_data,
    input  logic                             busy_bit,
    output logic [DATA_W-1:0]                rd_data,
    output logic                             rd_busy
);

    wr_match_t m;

    assign m = wr_match(wr_en, wr_addr, MAX_AW'(rd_addr));

    always_comb begin
        rd_data = '0;
        if (!gate && (rd_addr != '0)) begin
            rd_data = m.hit ? wr_data[m.idx] : arr_data;
        end
    end

    // A register being written this cycle is available through the bypass.
    assign rd_busy = !rst && (rd_addr != '0) && busy_bit && !m.hit;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write bypass, hardwired x0 and an issue/writeback busy scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2
) (
    input  logic          clk,
    input  logic          rst,
    regfile_mp_if.slave   bus
);

    localparam int AW = $clog2(NUM_REGS);

    logic [DATA_W-1:0]                mem [NUM_REGS];
    logic [NUM_REGS-1:0]              busy;
    logic [MAX_WR-1:0]                act_en;
    logic [MAX_WR-1:0][MAX_AW-1:0]    act_addr;
    logic [MAX_WR-1:0][DATA_W-1:0]    act_data;
    wr_match_t                        reg_match [NUM_REGS];
    logic                             rd_gate;

    // Writes are only live outside reset and stall; unused padded ports stay idle.
    always_comb begin
        act_en   = '0;
        act_addr = '0;
        act_data = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            act_en[k]   = bus.wr_en[k] && !rst && !bus.stall;
            act_addr[k] = MAX_AW'(bus.wr_addr[k]);
            act_data[k] = bus.wr_data[k];
        end
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_match
        assign reg_match[r] = wr_match(act_en, act_addr, MAX_AW'(r));
    end

    // Issue set beats writeback clear on the same register: the issuer is younger.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                mem[r] <= '0;
            end
            busy <= '0;
        end else if (!bus.stall) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (reg_match[r].hit) begin
                    mem[r] <= act_data[reg_match[r].idx];
                end
                if (bus.iss_en && (bus.iss_addr == AW'(r))) begin
                    busy[r] <= 1'b1;
                end else if (reg_match[r].hit) begin
                    busy[r] <= 1'b0;
                end
            end
            busy[0] <= 1'b0;
        end
    end

    assign rd_gate = rst || bus.stall || !bus.rd_en;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        regfile_bypass_mux #(
            .DATA_W (DATA_W),
            .AW     (AW)
        ) u_mux (
            .rst      (rst),
            .gate     (rd_gate),
            .rd_addr  (bus.rd_addr[i]),
            .wr_en    (act_en),
            .wr_addr  (act_addr),
            .wr_data  (act_data),
            .arr_data (mem[bus.rd_addr[i]]),
            .busy_bit (busy[bus.rd_addr[i]]),
            .rd_data  (bus.rd_data[i]),
            .rd_busy  (bus.rd_busy[i])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed vector bench for regfile_mp: reset sweep, table of single-cycle vectors, full write/readback sweep.
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int NRD = 2;
    localparam int NWR = 2;

    typedef struct {
        string       name;
        logic        rst;
        logic        stall;
        logic        rd_en;
        reg_addr_t   ra0;
        reg_addr_t   ra1;
        logic [1:0]  we;
        reg_addr_t   wa0;
        logic [31:0] wd0;
        reg_addr_t   wa1;
        logic [31:0] wd1;
        logic        iss;
        reg_addr_t   ia;
        logic [31:0] ed0;
        logic [31:0] ed1;
        logic [1:0]  eb;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_compared   = 0;
    int   n_mismatched = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR)) bus ();

    regfile_mp #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic vec_t mk(
        string n, logic r, logic s, logic re, reg_addr_t a0, reg_addr_t a1,
        logic [1:0] we, reg_addr_t wa0, logic [31:0] wd0, reg_addr_t wa1, logic [31:0] wd1,
        logic iss, reg_addr_t ia, logic [31:0] ed0, logic [31:0] ed1, logic [1:0] eb
    );
        vec_t v;
        v.name = n; v.rst = r; v.stall = s; v.rd_en = re; v.ra0 = a0; v.ra1 = a1;
        v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.iss = iss; v.ia = ia; v.ed0 = ed0; v.ed1 = ed1; v.eb = eb;
        return v;
    endfunction

    task automatic check_value(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        rst            = v.rst;
        bus.stall      = v.stall;
        bus.rd_en      = v.rd_en;
        bus.rd_addr[0] = v.ra0;
        bus.rd_addr[1] = v.ra1;
        bus.wr_en      = v.we;
        bus.wr_addr[0] = v.wa0;
        bus.wr_data[0] = v.wd0;
        bus.wr_addr[1] = v.wa1;
        bus.wr_data[1] = v.wd1;
        bus.iss_en     = v.iss;
        bus.iss_addr   = v.ia;
    endtask

    task automatic check_output(input vec_t v);
        #1;
        check_value({v.name, " rd_data0"}, bus.rd_data[0], v.ed0);
        check_value({v.name, " rd_data1"}, bus.rd_data[1], v.ed1);
        check_value({v.name, " rd_busy"}, 32'(bus.rd_busy), 32'(v.eb));
    endtask

    task automatic run_cycle(input vec_t v);
        apply_stimulus(v);
        check_output(v);
        @(negedge clk);
    endtask

    initial begin
        // name              rst st re ra0 ra1 we     wa0 wd0           wa1 wd1          iss ia  ed0           ed1           eb
        vecs.push_back(mk("x0 write",     0, 0, 1, 0,  0,  2'b01, 0,  32'hFFFF_FFFF, 0,  32'h0,       0, 0,  32'h0,        32'h0,        2'b00));
        vecs.push_back(mk("x0 after",     0, 0, 1, 0,  1,  2'b00, 0,  32'h0,         0,  32'h0,       0, 0,  32'h0,        32'h0,        2'b00));
        vecs.push_back(mk("bypass x5",    0, 0, 1, 0,  5,  2'b01, 5,  32'h1234,      0,  32'h0,       0, 0,  32'h0,        32'h1234,     2'b00));
        vecs.push_back(mk("held x5",      0, 0, 1, 0,  5,  2'b00, 0,  32'h0,         0,  32'h0,       0, 0,  32'h0,        32'h1234,     2'b00));
        vecs.push_back(mk("conflict x7",  0, 0, 1, 7,  7,  2'b11, 7,  32'hA,         7,  32'hB,       0, 0,  32'hB,        32'hB,        2'b00));
        vecs.push_back(mk("held x7",      0, 0, 1, 7,  5,  2'b00, 0,  32'h0,         0,  32'h0,       0, 0,  32'hB,        32'h1234,     2'b00));
        vecs.push_back(mk("wr x3 iss x11",0, 0, 1, 3,  11, 2'b10, 0,  32'h0,         3,  32'h33,      1, 11, 32'h33,       32'h0,        2'b00));
        vecs.push_back(mk("busy x11",     0, 0, 1, 3,  11, 2'b00, 0,  32'h0,         0,  32'h0,       0, 0,  32'h33,       32'h0,        2'b10));
        vecs.push_back(mk("stall",        0, 1, 1, 3,  11, 2'b11, 3,  32'h55,        11, 32'h77,      1, 12, 32'h0,        32'h0,        2'b10));
        vecs.push_back(mk("post stall",   0, 0, 1, 3,  12, 2'b00, 0,  32'h0,         0,  32'h0,       0, 0,  32'h33,       32'h0,        2'b00));
        vecs.push_back(mk("x11 dropped",  0, 0, 1, 11, 3,  2'b00, 0,  32'h0,         0,  32'h0,       0, 0,  32'h0,        32'h33,       2'b01));
        vecs.push_back(mk("rd_en low",    0, 0, 0, 3,  11, 2'b00, 0,  32'h0,         0,  32'h0,       0, 0,  32'h0,        32'h0,        2'b10));
        vecs.push_back(mk("iss x9",       0, 0, 1, 9,  0,  2'b00, 0,  32'h0,         0,  32'h0,       1, 9,  32'h0,        32'h0,        2'b00));
        vecs.push_back(mk("busy x9",      0, 0, 1, 9,  0,  2'b00, 0,  32'h0,         0,  32'h0,       0, 0,  32'h0,        32'h0,        2'b01));
        vecs.push_back(mk("wb x9",        0, 0, 1, 9,  9,  2'b01, 9,  32'h99,        0,  32'h0,       0, 0,  32'h99,       32'h99,       2'b00));
        vecs.push_back(mk("x9 cleared",   0, 0, 1, 9,  0,  2'b00, 0,  32'h0,         0,  32'h0,       0, 0,  32'h99,       32'h0,        2'b00));
        vecs.push_back(mk("iss+wb x9",    0, 0, 1, 9,  0,  2'b10, 0,  32'h0,         9,  32'hAA,      1, 9,  32'hAA,       32'h0,        2'b00));
        vecs.push_back(mk("set wins x9",  0, 0, 1, 9,  0,  2'b00, 0,  32'h0,         0,  32'h0,       0, 0,  32'hAA,       32'h0,        2'b01));
        vecs.push_back(mk("wb x11",       0, 0, 1, 11, 9,  2'b01, 11, 32'h11,        0,  32'h0,       0, 0,  32'h11,       32'hAA,       2'b10));
        vecs.push_back(mk("x11 free",     0, 0, 1, 11, 9,  2'b00, 0,  32'h0,         0,  32'h0,       0, 0,  32'h11,       32'hAA,       2'b10));
        vecs.push_back(mk("mid reset",    1, 0, 1, 4,  9,  2'b01, 4,  32'h44,        0,  32'h0,       1, 4,  32'h0,        32'h0,        2'b00));
        vecs.push_back(mk("x4 dropped",   0, 0, 1, 4,  9,  2'b00, 0,  32'h0,         0,  32'h0,       0, 0,  32'h0,        32'h0,        2'b00));
        vecs.push_back(mk("array clear",  0, 0, 1, 7,  5,  2'b00, 0,  32'h0,         0,  32'h0,       0, 0,  32'h0,        32'h0,        2'b00));

        run_cycle(mk("reset", 1, 0, 1, 3, 0, 2'b00, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 2'b00));

        // Every address reads zero and idle straight after reset.
        for (int a = 0; a < NR; a += 2) begin
            run_cycle(mk("reset sweep", 0, 0, 1, reg_addr_t'(a), reg_addr_t'(a + 1),
                         2'b00, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 2'b00));
        end

        foreach (vecs[i]) begin
            run_cycle(vecs[i]);
        end

        // Fill every register on alternating ports, checking the bypass, then read all back.
        for (int r = 1; r < NR; r++) begin
            if (r % 2 == 0) begin
                run_cycle(mk("fill p0", 0, 0, 1, reg_addr_t'(r), 0, 2'b01, reg_addr_t'(r), 32'h1000 + r,
                             0, 32'h0, 0, 0, 32'h1000 + r, 32'h0, 2'b00));
            end else begin
                run_cycle(mk("fill p1", 0, 0, 1, 0, reg_addr_t'(r), 2'b10, 0, 32'h0, reg_addr_t'(r),
                             32'h1000 + r, 0, 0, 32'h0, 32'h1000 + r, 2'b00));
            end
        end
        for (int r = 0; r < NR; r++) begin
            int q;
            q = NR - 1 - r;
            run_cycle(mk("readback", 0, 0, 1, reg_addr_t'(r), reg_addr_t'(q), 2'b00, 0, 32'h0, 0, 32'h0, 0, 0,
                         (r == 0) ? 32'h0 : 32'h1000 + r, (q == 0) ? 32'h0 : 32'h1000 + q, 2'b00));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
